// File: rtl/fsm_trace_monitor.sv
// ---------------------------------------------------------------------------
// fsm_trace_monitor
//
// Passive observer for the four-state control FSM (A=00, S1=01, S2=10, B=11).
// On every qualified cycle it samples the FSM state and output_signal. It
// keeps a saturating entry counter per state and logs each state change as a
// {from,to} record into a small FIFO. A valid/ready handshake drains that
// FIFO. Sticky flags report a dropped record and, when the consistency checks
// are built, illegal transitions and output/state mismatches.
//
// Build option:
//   FSM_MON_CHECK_EN  defined   -> illegal/out_err check logic is built
//                     undefined -> illegal and out_err are tied to 0
//
// Parameters:
//   DEPTH  transition FIFO depth in records (power of two, >= 2)
//   CNT_W  width of each per-state entry counter
//
// Ports:
//   clk        in   single clock, rising edge
//   reset_n    in   synchronous active-low reset
//   sample_en  in   qualifies state_in / out_in this cycle
//   state_in   in   FSM state code
//   out_in     in   FSM output_signal
//   clr        in   synchronous clear of counters, FIFO and sticky flags
//   cnt_sel    in   selects which state's counter drives cnt_out
//   cnt_out    out  entry count of state cnt_sel (mux of registered counters)
//   rec_valid  out  FIFO non-empty
//   rec_data   out  head record {from[3:2], to[1:0]}
//   rec_ready  in   consumer accepts head when rec_valid
//   overflow   out  sticky: a record was dropped
//   illegal    out  sticky: illegal transition seen
//   out_err    out  sticky: out_in inconsistent with state_in
// ---------------------------------------------------------------------------
module fsm_trace_monitor #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sample_en,
    input  logic [1:0]       state_in,
    input  logic             out_in,
    input  logic             clr,
    input  logic [1:0]       cnt_sel,
    output logic [CNT_W-1:0] cnt_out,
    output logic             rec_valid,
    output logic [3:0]       rec_data,
    input  logic             rec_ready,
    output logic             overflow,
    output logic             illegal,
    output logic             out_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

    localparam logic [1:0] ST_A  = 2'b00;
    localparam logic [1:0] ST_S1 = 2'b01;
    localparam logic [1:0] ST_S2 = 2'b10;
    localparam logic [1:0] ST_B  = 2'b11;

    // Saturating increment: the counter sticks at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) return v;
        return v + CNT_W'(1);
    endfunction

    // ---------------- state ----------------
    logic [1:0]       prev_state_q;
    logic             prev_vld_q;
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];

    logic [3:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             rec_valid_q, rec_valid_d;
    logic [3:0]       rec_data_q, rec_data_d;
    logic             overflow_q, overflow_d;

    // ---------------- sample decode ----------------
    logic       is_first;
    logic       is_change;
    logic       count_inc;
    logic [3:0] push_rec;
    logic       full;
    logic       pop;
    logic       push_acc;
    logic       drop;
    logic [PTR_W-1:0] rd_nxt;

    assign is_first  = sample_en & ~prev_vld_q;
    assign is_change = sample_en & prev_vld_q & (state_in != prev_state_q);
    assign count_inc = is_first | is_change;
    assign push_rec  = {prev_state_q, state_in};

    assign full     = (occ_q == OCC_FULL);
    assign pop      = rec_valid_q & rec_ready;
    // A pop in the same cycle frees the slot a full FIFO needs for the push.
    assign push_acc = is_change & (~full | pop);
    assign drop     = is_change & full & ~pop;
    assign rd_nxt   = rd_ptr_q + PTR_W'(1);

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = cnt_q[i];
            if (count_inc && (state_in == 2'(i)))
                cnt_d[i] = sat_inc(cnt_q[i]);
        end
    end

    assign cnt_out = cnt_q[cnt_sel];

    // ---------------- FIFO bookkeeping ----------------
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        occ_d      = occ_q;
        rec_data_d = rec_data_q;
        overflow_d = overflow_q | drop;

        if (push_acc) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)      rd_ptr_d = rd_nxt;

        case ({push_acc, pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase

        // The head is kept in its own register so rec_data is a flop output
        // and reads 0 whenever the FIFO is empty. When more than one record
        // is queued, the slot after the head still holds old data that this
        // edge does not overwrite.
        if (pop) begin
            if (occ_q > OCC_W'(1))
                rec_data_d = mem_q[rd_nxt];
            else if (push_acc)
                rec_data_d = push_rec;
            else
                rec_data_d = 4'h0;
        end else if (occ_q == '0 && push_acc) begin
            rec_data_d = push_rec;
        end

        rec_valid_d = (occ_d != '0);
    end

    // ---------------- control registers ----------------
    always_ff @(posedge clk) begin
        if (!reset_n || clr) begin
            prev_state_q <= ST_A;
            prev_vld_q   <= 1'b0;
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            occ_q        <= '0;
            rec_valid_q  <= 1'b0;
            rec_data_q   <= 4'h0;
            overflow_q   <= 1'b0;
        end else begin
            if (count_inc) begin
                prev_state_q <= state_in;
                prev_vld_q   <= 1'b1;
            end
            for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            rec_valid_q <= rec_valid_d;
            rec_data_q  <= rec_data_d;
            overflow_q  <= overflow_d;
        end
    end

    // ---------------- record storage (no reset) ----------------
    always_ff @(posedge clk) begin
        if (push_acc && reset_n && !clr)
            mem_q[wr_ptr_q] <= push_rec;
    end

    assign rec_valid = rec_valid_q;
    assign rec_data  = rec_data_q;
    assign overflow  = overflow_q;

    // ---------------- consistency checks ----------------
`ifdef FSM_MON_CHECK_EN
    logic illegal_q, illegal_d;
    logic out_err_q, out_err_d;
    logic exp_out;

    // output_signal is asserted in A and S2 only.
    assign exp_out = (state_in == ST_A) || (state_in == ST_S2);

    always_comb begin
        illegal_d = illegal_q;
        out_err_d = out_err_q;
        // S2 may only be entered from A; the record is still logged.
        if (is_change && (state_in == ST_S2) &&
            ((prev_state_q == ST_S1) || (prev_state_q == ST_B)))
            illegal_d = 1'b1;
        if (sample_en && (out_in != exp_out))
            out_err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n || clr) begin
            illegal_q <= 1'b0;
            out_err_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
            out_err_q <= out_err_d;
        end
    end

    assign illegal = illegal_q;
    assign out_err = out_err_q;
`else
    logic unused_out_in;
    assign unused_out_in = out_in;
    assign illegal = 1'b0;
    assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_fsm_trace_monitor.sv
// ---------------------------------------------------------------------------
// tb_fsm_trace_monitor
//
// Directed bench for fsm_trace_monitor. It uses two instances that share the
// stimulus: DEPTH=8/CNT_W=16 for the main checks, and CNT_W=2 for counter
// saturation. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_fsm_trace_monitor;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        sample_en;
    logic [1:0]  state_in;
    logic        out_in;
    logic        clr;
    logic [1:0]  cnt_sel;
    logic [15:0] cnt_out;
    logic        rec_valid;
    logic [3:0]  rec_data;
    logic        rec_ready;
    logic        overflow;
    logic        illegal;
    logic        out_err;

    logic [1:0]  cnt_out2;
    logic        rec_valid2;
    logic [3:0]  rec_data2;
    logic        overflow2;
    logic        illegal2;
    logic        out_err2;

    int vec_cnt = 0;
    int err_cnt = 0;

    localparam logic [1:0] A = 2'b00, S1 = 2'b01, S2 = 2'b10, B = 2'b11;

`ifdef FSM_MON_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    always #5 clk = ~clk;

    fsm_trace_monitor #(.DEPTH(8), .CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .sample_en(sample_en),
        .state_in(state_in), .out_in(out_in), .clr(clr), .cnt_sel(cnt_sel),
        .cnt_out(cnt_out), .rec_valid(rec_valid), .rec_data(rec_data),
        .rec_ready(rec_ready), .overflow(overflow), .illegal(illegal),
        .out_err(out_err)
    );

    fsm_trace_monitor #(.DEPTH(8), .CNT_W(2)) dut_sat (
        .clk(clk), .reset_n(reset_n), .sample_en(sample_en),
        .state_in(state_in), .out_in(out_in), .clr(clr), .cnt_sel(cnt_sel),
        .cnt_out(cnt_out2), .rec_valid(rec_valid2), .rec_data(rec_data2),
        .rec_ready(rec_ready), .overflow(overflow2), .illegal(illegal2),
        .out_err(out_err2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic out_for(input logic [1:0] s);
        return (s == A) || (s == S2);
    endfunction

    task automatic sample_o(input logic [1:0] s, input logic o);
        sample_en = 1'b1;
        state_in  = s;
        out_in    = o;
        step();
        sample_en = 1'b0;
    endtask

    task automatic sample(input logic [1:0] s);
        sample_o(s, out_for(s));
    endtask

    task automatic chk_cnt(input string tag, input logic [1:0] sel, input logic [31:0] exp);
        cnt_sel = sel;
        #1;
        chk(tag, {16'h0, cnt_out}, exp);
    endtask

    task automatic do_clr();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; sample_en = 1'b0; state_in = A; out_in = 1'b1;
        clr = 1'b0; cnt_sel = A; rec_ready = 1'b0;
        #1;
        step(); step();

        // Reset state
        chk("rst_valid", rec_valid, 0);
        chk("rst_data", rec_data, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_outerr", out_err, 0);
        chk_cnt("rst_cnt_a", A, 0);
        chk_cnt("rst_cnt_b", B, 0);
        reset_n = 1'b1;
        step();

        // Basic sequence A,A,S1,B,A with the consumer always ready
        rec_ready = 1'b1;
        sample(A);
        chk("seq_first_norec", rec_valid, 0);
        sample(A);
        chk("seq_same_norec", rec_valid, 0);
        sample(S1);
        chk("seq_rec1_vld", rec_valid, 1);
        chk("seq_rec1", rec_data, 4'h1);
        sample(B);
        chk("seq_rec2", rec_data, 4'h7);
        sample(A);
        chk("seq_rec3", rec_data, 4'hC);
        step();
        chk("seq_empty", rec_valid, 0);
        chk_cnt("seq_cnt_a", A, 2);
        chk_cnt("seq_cnt_s1", S1, 1);
        chk_cnt("seq_cnt_b", B, 1);
        chk_cnt("seq_cnt_s2", S2, 0);

        // Overflow: 9 transitions into a depth-8 FIFO with no consumer
        do_clr();
        rec_ready = 1'b0;
        sample(A);
        for (int i = 0; i < 8; i++) sample((i % 2 == 0) ? S1 : A);
        chk("ovf_full_noflag", overflow, 0);
        chk("ovf_head_hold", rec_data, 4'h1);
        sample(S1);
        chk("ovf_flag", overflow, 1);
        chk("ovf_head_after", rec_data, 4'h1);
        rec_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("ovf_drain_vld", rec_valid, 1);
            chk("ovf_drain_data", rec_data, (i % 2 == 0) ? 4'h1 : 4'h4);
            step();
        end
        chk("ovf_drained", rec_valid, 0);
        chk("ovf_sticky", overflow, 1);

        // Full FIFO, push and pop in the same cycle
        do_clr();
        chk("clr_ovf", overflow, 0);
        rec_ready = 1'b0;
        sample(A);
        for (int i = 0; i < 8; i++) sample((i % 2 == 0) ? S1 : A);
        rec_ready = 1'b1;
        sample(S2);
        rec_ready = 1'b0;
        chk("fullpp_noovf", overflow, 0);
        chk("fullpp_head", rec_data, 4'h4);
        rec_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("fullpp_drain_vld", rec_valid, 1);
            chk("fullpp_drain_data", rec_data,
                (i == 7) ? 4'h2 : ((i % 2 == 0) ? 4'h4 : 4'h1));
            step();
        end
        chk("fullpp_drained", rec_valid, 0);

        // Consistency checks
        do_clr();
        sample(S1);
        chk("chk_clean_illegal", illegal, 0);
        sample(S2);
        chk("chk_illegal", illegal, CHK);
        chk("chk_rec_kept", rec_data, 4'h6);
        chk("chk_outerr_clean", out_err, 0);
        sample_o(S1, 1'b1);
        chk("chk_outerr", out_err, CHK);
        step();
        chk("chk_illegal_sticky", illegal, CHK);
        chk("chk_outerr_sticky", out_err, CHK);

        // Counter saturation (CNT_W=2 instance) vs wide counter
        do_clr();
        chk("clr_illegal", illegal, 0);
        chk("clr_outerr", out_err, 0);
        sample(A);
        for (int i = 0; i < 5; i++) begin
            sample(S1);
            sample(A);
        end
        cnt_sel = A;
        #1;
        chk("sat_a_narrow", cnt_out2, 3);
        chk("sat_a_wide", cnt_out, 6);
        cnt_sel = S1;
        #1;
        chk("sat_s1_narrow", cnt_out2, 3);
        chk("sat_s1_wide", cnt_out, 5);

        // Mid-stream clear with records queued, then reset
        do_clr();
        rec_ready = 1'b0;
        sample(A);
        sample(S1);
        sample(A);
        sample(S1);
        chk("mid_queued", rec_valid, 1);
        clr = 1'b1;
        sample_o(B, 1'b0);
        clr = 1'b0;
        chk("mid_clr_valid", rec_valid, 0);
        chk("mid_clr_data", rec_data, 0);
        chk_cnt("mid_clr_cnt_b", B, 0);
        chk_cnt("mid_clr_cnt_s1", S1, 0);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        sample(S2);
        chk("post_first_norec", rec_valid, 0);
        chk_cnt("post_cnt_s2", S2, 1);
        chk_cnt("post_cnt_a", A, 0);
        chk("post_flags", {overflow, illegal, out_err}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
